bip_top: RTL and testbench
==========================

# bip_top

Top level of the single-cycle BIP-I accumulator processor: program ROM, data RAM, program counter, accumulator datapath, control decoder and a run-cycle counter. Once `start` is high, the processor executes one 16-bit instruction per clock from address 0 until HLT. It exposes the accumulator, its low byte for board LEDs, and the number of executed cycles.

## Interface
- `PC_WIDTH`, 11: program counter / ROM address width (2048 words).
- `DADDR_WIDTH`, 10: data RAM address width (1024 x 16).
- `DATA_WIDTH`, 16: accumulator, instruction and memory word width.
- `clk` in 1: single system clock, rising-edge.
- `reset` in 1: reset is synchronous and active-high.
- `start` in 1: level run-enable; the processor executes only while high.
- `led_acc` out 8: `acumulador[7:0]`, combinational copy.
- `acumulador` out 16: accumulator register.
- `clk_count` out 8: count of executed instruction cycles.

## Operation
- Instruction format: `[15:11]` opcode, `[10:0]` operand. Immediates are the operand sign-extended to 16 bits. Data address is `operand[DADDR_WIDTH-1:0]`.
- Opcodes:
  - 00000 HLT: set halted; PC and ACC hold.
  - 00001 STO: RAM[addr] <= ACC.
  - 00010 LD: ACC <= RAM[addr].
  - 00011 LDI: ACC <= imm.
  - 00100 ADD: ACC <= ACC + RAM[addr].
  - 00101 ADDI: ACC <= ACC + imm.
  - 00110 SUB: ACC <= ACC − RAM[addr].
  - 00111 SUBI: ACC <= ACC − imm.
  - Other opcodes: NOP.
- Arithmetic is 16-bit two's complement; carry and overflow are discarded (wraps).
- Except for HLT, PC <= PC+1 for each executed instruction. PC wraps from 2047 to 0.
- Program ROM: asynchronous read, contents fixed at build. The default image is:
  - 0: LDI 5
  - 1: STO 0
  - 2: ADDI 3
  - 3: ADD 0
  - 4: SUBI 1
  - 5: STO 1
  - 6: LD 0
  - 7: SUB 1
  - 8: HLT
  - 9..: all HLT
- Data RAM: asynchronous read, synchronous write on a STO cycle. Zero at configuration; not cleared by `reset`.
- Run condition: `start`=1 AND not halted AND `reset`=0.
  - Run low: PC, ACC, RAM and `clk_count` hold.
- `clk_count` increments on every run cycle, including the HLT cycle. It saturates at 255.
- Halted is sticky until `reset`. Dropping `start` does not clear it.

## Timing
- Configuration values: PC=0, ACC=0, `clk_count`=0, halted=0. No reset is needed before the first run.
- Reset high at a rising edge gives PC=0, ACC=0, `clk_count`=0, halted=0. Reset overrides `start` and aborts execution mid-program; RAM keeps its contents.
- Latency: the instruction at PC completes at the rising edge where run=1. ACC, RAM, PC and `clk_count` all update at that same edge.
- `start` is sampled only at rising edges. An edge with `start` low is a stall.
- STO then LD/ADD/SUB to the same address on the next cycle reads the newly stored value.
- `led_acc` follows `acumulador` with no extra register.

## Test plan
- Power-up with no reset, `start`=0 for 3 edges → `acumulador`=0, `clk_count`=0, `led_acc`=0, PC=0.
- Raise `start`, run the default program 9 edges → ACC sequence 5, 5, 8, 13, 12, 12, 5, 0xFFF9, 0xFFF9. Final RAM[0]=5, RAM[1]=12, `clk_count`=9, `led_acc`=0xF9.
- After HLT, keep clocking 20 edges → ACC stays 0xFFF9 and `clk_count` stays 9, with `start` either high or low.
- Drop `start` after 3 edges of the default program, hold 5 edges, then raise it → ACC holds 8 during the stall. Final ACC=0xFFF9, `clk_count`=9.
- Assert `reset` for 1 edge after 4 run edges (ACC=13) → ACC=0, `clk_count`=0, PC=0. Rerun → identical final results.
- Wrap check with an alternate ROM: LDI 0x3FF (1023), ADDI 0x3FF repeated until ACC exceeds 0x7FFF, then SUBI −1 (0x7FF) → 16-bit wrap with no flags.
  - `clk_count` saturates at 255 in a loop-free 300-NOP program.

Source files
------------

// File: rtl/bip_top.sv
// BIP-I single-cycle accumulator processor: ROM, data RAM, PC, accumulator, decoder, run counter.
// One instruction completes per rising edge while the processor runs. PROGRAM selects the ROM image.
module bip_top #(
    parameter int PC_WIDTH    = 11,
    parameter int DADDR_WIDTH = 10,
    parameter int DATA_WIDTH  = 16,
    parameter int PROGRAM     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic [7:0]            led_acc,
    output logic [DATA_WIDTH-1:0] acumulador,
    output logic [7:0]            clk_count
);
    localparam int OP_W   = 5;
    localparam int OPND_W = DATA_WIDTH - OP_W;

    localparam logic [OP_W-1:0] OP_HLT  = 5'b00000;
    localparam logic [OP_W-1:0] OP_STO  = 5'b00001;
    localparam logic [OP_W-1:0] OP_LD   = 5'b00010;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00011;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00100;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b00101;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00110;
    localparam logic [OP_W-1:0] OP_SUBI = 5'b00111;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11111;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [OPND_W-1:0] operand;
    } instr_t;

    typedef struct packed {
        logic                  acc_we;
        logic                  ram_we;
        logic                  halt;
        logic [DATA_WIDTH-1:0] acc_nxt;
    } ctrl_t;

    typedef enum logic {S_RUN, S_HALT} state_e;

    function automatic instr_t enc(input logic [OP_W-1:0] op, input int operand);
        instr_t w;
        w.op      = op;
        w.operand = OPND_W'(operand);
        return w;
    endfunction

    // Image 0: default demo program; 1: 16-bit wrap test; 2: NOP-only, no HLT.
    function automatic instr_t rom_word(input logic [PC_WIDTH-1:0] a);
        int ai;
        instr_t w;
        ai = int'(a);
        w  = enc(OP_HLT, 0);
        case (PROGRAM)
            1: begin
                if (ai == 0)       w = enc(OP_LDI, 1023);
                else if (ai <= 32) w = enc(OP_ADDI, 1023);
                else if (ai == 33) w = enc(OP_SUBI, -1);
            end
            2: w = enc(OP_NOP, 0);
            default: begin
                case (ai)
                    0: w = enc(OP_LDI, 5);
                    1: w = enc(OP_STO, 0);
                    2: w = enc(OP_ADDI, 3);
                    3: w = enc(OP_ADD, 0);
                    4: w = enc(OP_SUBI, 1);
                    5: w = enc(OP_STO, 1);
                    6: w = enc(OP_LD, 0);
                    7: w = enc(OP_SUB, 1);
                    default: w = enc(OP_HLT, 0);
                endcase
            end
        endcase
        return w;
    endfunction

    // Declaration initialisers give the power-up state; reset is optional before the first run.
    logic [PC_WIDTH-1:0]   pc  = '0;
    logic [DATA_WIDTH-1:0] acc = '0;
    logic [7:0]            cnt = '0;
    state_e                state = S_RUN;
    state_e                state_nxt;
    logic [DATA_WIDTH-1:0] ram [2**DADDR_WIDTH] = '{default: '0};

    instr_t                 instr;
    ctrl_t                  ctrl;
    logic [DATA_WIDTH-1:0]  imm;
    logic [DADDR_WIDTH-1:0] daddr;
    logic [DATA_WIDTH-1:0]  rdata;
    logic                   run;

    assign instr = rom_word(pc);
    assign imm   = {{(DATA_WIDTH-OPND_W){instr.operand[OPND_W-1]}}, instr.operand};
    assign daddr = instr.operand[DADDR_WIDTH-1:0];
    assign rdata = ram[daddr];
    assign run   = start && (state == S_RUN) && !reset;

    always_comb begin
        ctrl = '0;
        ctrl.acc_nxt = acc;
        case (instr.op)
            OP_HLT:  ctrl.halt = 1'b1;
            OP_STO:  ctrl.ram_we = 1'b1;
            OP_LD:   begin ctrl.acc_we = 1'b1; ctrl.acc_nxt = rdata;       end
            OP_LDI:  begin ctrl.acc_we = 1'b1; ctrl.acc_nxt = imm;         end
            OP_ADD:  begin ctrl.acc_we = 1'b1; ctrl.acc_nxt = acc + rdata; end
            OP_ADDI: begin ctrl.acc_we = 1'b1; ctrl.acc_nxt = acc + imm;   end
            OP_SUB:  begin ctrl.acc_we = 1'b1; ctrl.acc_nxt = acc - rdata; end
            OP_SUBI: begin ctrl.acc_we = 1'b1; ctrl.acc_nxt = acc - imm;   end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        if (run && ctrl.halt) state_nxt = S_HALT;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_RUN;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc  <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (run) begin
            if (!ctrl.halt)   pc  <= pc + 1'b1;
            if (ctrl.acc_we)  acc <= ctrl.acc_nxt;
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
        end
    end

    // RAM is deliberately outside the reset domain so contents survive a reset.
    always_ff @(posedge clk) begin
        if (run && ctrl.ram_we) ram[daddr] <= acc;
    end

    assign acumulador = acc;
    assign led_acc    = acc[7:0];
    assign clk_count  = cnt;
endmodule

// File: tb/tb_bip_top.sv
// Bench for bip_top: instruction-level reference interpreter for three ROM images,
// per-cycle output comparison, plus hand-computed literal checkpoints.
module tb_bip_top;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start [3] = '{1'b0, 1'b0, 1'b0};
    logic [7:0]  led [3];
    logic [15:0] acc [3];
    logic [7:0]  cnt [3];

    always #5 clk = ~clk;

    bip_top #(.PROGRAM(0)) u_def (.clk(clk), .reset(reset), .start(start[0]),
        .led_acc(led[0]), .acumulador(acc[0]), .clk_count(cnt[0]));
    bip_top #(.PROGRAM(1)) u_wrap (.clk(clk), .reset(reset), .start(start[1]),
        .led_acc(led[1]), .acumulador(acc[1]), .clk_count(cnt[1]));
    bip_top #(.PROGRAM(2)) u_nop (.clk(clk), .reset(reset), .start(start[2]),
        .led_acc(led[2]), .acumulador(acc[2]), .clk_count(cnt[2]));

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Reference interpreter state, one slot per ROM image.
    int mrom [3][2048];
    int mram [3][1024];
    int macc [3];
    int mpc  [3];
    int mcnt [3];
    bit mhalt[3];

    initial begin
        int def_img [9] = '{16'h1805, 16'h0800, 16'h2803, 16'h2000, 16'h3801,
                            16'h0801, 16'h1000, 16'h3001, 16'h0000};
        for (int a = 0; a < 2048; a++) begin
            mrom[0][a] = (a < 9) ? def_img[a] : 0;
            mrom[1][a] = (a == 0) ? 16'h1BFF : (a <= 32) ? 16'h2BFF : (a == 33) ? 16'h3FFF : 0;
            mrom[2][a] = 16'hF800;
        end
        for (int k = 0; k < 3; k++) begin
            macc[k] = 0; mpc[k] = 0; mcnt[k] = 0; mhalt[k] = 0;
            for (int a = 0; a < 1024; a++) mram[k][a] = 0;
        end
    end

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (reset) begin
                macc[k] <= 0; mpc[k] <= 0; mcnt[k] <= 0; mhalt[k] <= 0;
            end else if (start[k] && !mhalt[k]) begin
                automatic int w    = mrom[k][mpc[k]];
                automatic int op   = w >> 11;
                automatic int opnd = w & 'h7FF;
                automatic int imm  = (opnd >= 1024) ? opnd - 2048 : opnd;
                automatic int ad   = opnd & 'h3FF;
                automatic int a    = macc[k];
                case (op)
                    0: a = a;
                    1: mram[k][ad] <= macc[k];
                    2: a = mram[k][ad];
                    3: a = imm;
                    4: a = a + mram[k][ad];
                    5: a = a + imm;
                    6: a = a - mram[k][ad];
                    7: a = a - imm;
                    default: a = a;
                endcase
                macc[k] <= a & 'hFFFF;
                if (op == 0) mhalt[k] <= 1'b1;
                else         mpc[k] <= (mpc[k] + 1) % 2048;
                mcnt[k] <= (mcnt[k] < 255) ? mcnt[k] + 1 : 255;
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("acc[%0d]", k), int'(acc[k]), macc[k]);
            chk($sformatf("led[%0d]", k), int'(led[k]), macc[k] & 'hFF);
            chk($sformatf("cnt[%0d]", k), int'(cnt[k]), mcnt[k]);
        end
    end

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int seq [9] = '{16'h0005, 16'h0005, 16'h0008, 16'h000D, 16'h000C,
                        16'h000C, 16'h0005, 16'hFFF9, 16'hFFF9};
        // Power-up without reset, stalled.
        edges(3);
        chk("pwr_acc", int'(acc[0]), 0);
        chk("pwr_cnt", int'(cnt[0]), 0);
        chk("pwr_led", int'(led[0]), 0);

        // Default program straight through.
        start[0] = 1'b1;
        for (int i = 0; i < 9; i++) begin
            edges(1);
            chk($sformatf("seq%0d", i), int'(acc[0]), seq[i]);
        end
        chk("run_cnt", int'(cnt[0]), 9);
        chk("run_led", int'(led[0]), 'hF9);
        chk("ram0", int'(u_def.ram[0]), 5);
        chk("ram1", int'(u_def.ram[1]), 12);

        // Halted state is sticky with start high or low.
        edges(10);
        start[0] = 1'b0;
        edges(10);
        chk("halt_acc", int'(acc[0]), 'hFFF9);
        chk("halt_cnt", int'(cnt[0]), 9);
        start[0] = 1'b1;
        edges(3);
        chk("halt_cnt2", int'(cnt[0]), 9);

        // Reset, then stall mid-program.
        start[0] = 1'b0;
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        chk("rst_acc", int'(acc[0]), 0);
        chk("rst_cnt", int'(cnt[0]), 0);
        start[0] = 1'b1;
        edges(3);
        start[0] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            edges(1);
            chk($sformatf("stall%0d", i), int'(acc[0]), 8);
        end
        start[0] = 1'b1;
        edges(8);
        chk("stall_acc", int'(acc[0]), 'hFFF9);
        chk("stall_cnt", int'(cnt[0]), 9);

        // Reset overriding start mid-program, then rerun.
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        edges(4);
        chk("mid_acc", int'(acc[0]), 13);
        reset = 1'b1;
        edges(1);
        reset = 1'b0;
        chk("mid_rst_acc", int'(acc[0]), 0);
        chk("mid_rst_cnt", int'(cnt[0]), 0);
        edges(12);
        chk("rerun_acc", int'(acc[0]), 'hFFF9);
        chk("rerun_cnt", int'(cnt[0]), 9);
        chk("rerun_ram1", int'(u_def.ram[1]), 12);

        // 16-bit wrap: 33*1023 = 0x83DF, then minus -1 gives 0x83E0.
        start[1] = 1'b1;
        edges(33);
        chk("wrap_mid", int'(acc[1]), 'h83DF);
        edges(10);
        chk("wrap_acc", int'(acc[1]), 'h83E0);
        chk("wrap_cnt", int'(cnt[1]), 35);

        // Counter saturation on a program with no HLT.
        start[2] = 1'b1;
        edges(254);
        chk("nop_254", int'(cnt[2]), 254);
        edges(46);
        chk("nop_sat", int'(cnt[2]), 255);
        chk("nop_acc", int'(acc[2]), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
